frame_draw_scheduler: RTL and testbench
=======================================

Name: frame_draw_scheduler

Overview:
- Sequences all framebuffer drawing for one game frame: the clear engine, then each object draw engine (pipe1, pipe2, bird, ...) in fixed order.
- Muxes the active engine's pixel stream onto the single VGA_framebuffer write port.
- Issues a coordinate-snapshot pulse so every engine draws from the same object positions.
- Sits between the game-clock logic and the draw engines and framebuffer, replacing ad-hoc clear_en/clear_done locking.

Parameters:
- N_ENG, 4, number of draw engines; index 0 is always the clear engine; 1..N_ENG-1 are object engines drawn in ascending order.
- COORD_W, 11, pixel coordinate width.
- TIMEOUT_CYCLES, 400000, maximum clk cycles an engine may run before it is aborted (exceeds a 640x480 clear).

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-low reset.
- frame_tick  in  1  level signal (game_clk); each rising edge requests one frame.
- enable  in  1  game_enable; when 0, new requests are ignored.
- clr_status  in  1  synchronous clear of the sticky status flags.
- eng_start  out  N_ENG  one-hot, one-cycle start pulse to an engine.
- eng_done  in  N_ENG  one-cycle done pulse from each engine.
- eng_x  in  N_ENG*COORD_W  packed pixel x per engine; engine i occupies [i*COORD_W +: COORD_W].
- eng_y  in  N_ENG*COORD_W  packed pixel y per engine.
- eng_color  in  N_ENG  pixel color per engine.
- eng_wr  in  N_ENG  pixel-valid per engine.
- fb_x, fb_y  out  COORD_W  framebuffer write address.
- fb_color  out  1  framebuffer pixel color.
- fb_write  out  1  framebuffer write strobe.
- latch_coords  out  1  one-cycle pulse; the top level registers all object coordinates on it.
- busy  out  1  high from frame start until frame_done.
- frame_done  out  1  one-cycle pulse at the end of each frame.
- active_eng  out  $clog2(N_ENG)  index of the engine that currently owns the port.
- overrun  out  1  sticky; a request was dropped.
- timeout_err  out  1  sticky; an engine was aborted.

Behaviour:
- Reset values: all outputs 0, FSM IDLE, pending=0, idx=0, watchdog=0.
- Edge detect: tick_q registers frame_tick. A request is frame_tick & ~tick_q & enable.
- States are IDLE, SNAP, START, RUN, NEXT, DONE.
- IDLE: on a request go to SNAP.
- SNAP: latch_coords=1 for exactly this cycle; idx<=0; busy<=1; go to START.
- START: eng_start[idx]=1 for one cycle; watchdog<=0; go to RUN.
- RUN: the watchdog counts every cycle.
  - eng_done[idx] -> NEXT.
  - Otherwise, watchdog reaching TIMEOUT_CYCLES-1 -> set timeout_err, go to NEXT.
  - eng_done is sampled only in RUN. A done arriving in the START cycle, or from a non-active engine, is ignored.
- NEXT: if idx==N_ENG-1 go to DONE; otherwise idx<=idx+1 and go to START.
- DONE: frame_done=1 for one cycle; busy<=0.
  - If pending=1: clear pending, go to SNAP (busy re-asserts the next cycle).
  - Otherwise go to IDLE.
- Request while busy:
  - pending=0 -> pending<=1.
  - pending=1 -> overrun<=1 and the request is dropped.
  - A request in the DONE cycle itself counts as pending.
- Pixel mux (registered, 1-cycle latency):
  - In RUN: fb_x/fb_y/fb_color follow engine idx. fb_write<=eng_wr[idx].
  - Outside RUN: fb_write<=0; fb_x/fb_y/fb_color hold their last values.
  - Writes from non-active engines are discarded.
- active_eng equals idx. It is valid while busy and holds its last value otherwise.
- enable deasserted mid-frame: the current frame completes normally; pending is kept.
- clr_status clears overrun and timeout_err. If a set event occurs in the same cycle, set wins.
- Reset mid-frame returns to IDLE immediately. Engines must tolerate a missing completion.

Decomposition:
- Package draw_pkg holds:
  - COORD_W.
  - Enum sched_state_t {IDLE, SNAP, START, RUN, NEXT, DONE}.
  - Engine index constants ENG_CLEAR=0, ENG_PIPE1=1, ENG_PIPE2=2, ENG_BIRD=3.
- One sub-module, draw_watchdog: a counter with clear and enable inputs and a timeout output at TIMEOUT_CYCLES-1.

Test Plan:
- Bench uses N_ENG=4, TIMEOUT_CYCLES=16; every engine model asserts done 5 cycles after start.
- Single rising edge of frame_tick with enable=1:
  - latch_coords pulses 1 cycle after the edge.
  - eng_start pulses 0001, 0010, 0100, 1000 in order.
  - frame_done pulses once; busy is high throughout; no overrun.
- Engine 2 drives eng_wr=1, x=100, y=250, color=1 while active:
  - fb_write=1 with fb_x=100, fb_y=250 one cycle later.
  - Engine 1 writes during the same window never reach the fb port.
- Engine 1 never asserts done:
  - Abort after 16 RUN cycles; timeout_err=1; engine 2 starts next; frame still completes.
- Two further rising edges while busy:
  - First becomes pending; second sets overrun=1.
  - A second frame runs back-to-back; exactly 2 frame_done pulses in total.
- Rising edge with enable=0 -> no latch_coords, busy stays 0.
- reset asserted mid-RUN -> all outputs 0 immediately; the next rising edge starts a clean frame.
- clr_status pulsed -> overrun=0 and timeout_err=0.

Source files
------------

// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared types and constants for the frame draw scheduler
package draw_pkg;

  localparam int COORD_W = 11;

  typedef enum logic [2:0] {
    IDLE,
    SNAP,
    START,
    RUN,
    NEXT,
    DONE
  } sched_state_t;

  localparam int ENG_CLEAR = 0;
  localparam int ENG_PIPE1 = 1;
  localparam int ENG_PIPE2 = 2;
  localparam int ENG_BIRD  = 3;

endpackage

// File: rtl/draw_watchdog.sv
// rtl/draw_watchdog.sv - per-engine run-time counter with abort threshold
module draw_watchdog #(
  parameter int TIMEOUT_CYCLES = 400000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // count enabled cycles since the last clear, parking on the abort value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign timeout = (count == LAST);

endmodule

// File: rtl/frame_draw_scheduler.sv
// rtl/frame_draw_scheduler.sv - sequences the clear and object draw engines for one frame
module frame_draw_scheduler #(
  parameter int N_ENG          = 4,
  parameter int COORD_W        = draw_pkg::COORD_W,
  parameter int TIMEOUT_CYCLES = 400000,
  localparam int IDX_W         = (N_ENG > 1) ? $clog2(N_ENG) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_tick,
  input  logic                     enable,
  input  logic                     clr_status,
  output logic [N_ENG-1:0]         eng_start,
  input  logic [N_ENG-1:0]         eng_done,
  input  logic [N_ENG*COORD_W-1:0] eng_x,
  input  logic [N_ENG*COORD_W-1:0] eng_y,
  input  logic [N_ENG-1:0]         eng_color,
  input  logic [N_ENG-1:0]         eng_wr,
  output logic [COORD_W-1:0]       fb_x,
  output logic [COORD_W-1:0]       fb_y,
  output logic                     fb_color,
  output logic                     fb_write,
  output logic                     latch_coords,
  output logic                     busy,
  output logic                     frame_done,
  output logic [IDX_W-1:0]         active_eng,
  output logic                     overrun,
  output logic                     timeout_err
);

  import draw_pkg::*;

  sched_state_t     state;
  sched_state_t     state_nxt;
  logic             tick_q;
  logic             req;
  logic             pending;
  logic [IDX_W-1:0] idx;
  logic             done_hit;
  logic             last_eng;
  logic             wd_clear;
  logic             wd_en;
  logic             wd_timeout;
  logic             overrun_set;
  logic             timeout_set;

  assign req      = frame_tick & ~tick_q & enable;
  assign done_hit = eng_done[idx];
  assign last_eng = (idx == IDX_W'(N_ENG - 1));

  // a request arriving while a frame is in flight may queue exactly one more frame
  assign overrun_set = req && (state != IDLE) && (state != DONE) && pending;
  assign timeout_set = (state == RUN) && !done_hit && wd_timeout;

  draw_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_en),
    .timeout(wd_timeout)
  );

  // remember the previous game-clock level for rising-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= frame_tick;
    end
  end

  // scheduler state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state selection
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req) state_nxt = SNAP;
      SNAP:    state_nxt = START;
      START:   state_nxt = RUN;
      RUN:     if (done_hit || wd_timeout) state_nxt = NEXT;
      NEXT:    state_nxt = last_eng ? DONE : START;
      DONE:    state_nxt = (pending || req) ? SNAP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // per-state pulses towards engines, the top level and the watchdog
  always_comb begin
    latch_coords = (state == SNAP);
    frame_done   = (state == DONE);
    wd_clear     = (state == START);
    wd_en        = (state == RUN);
    eng_start    = '0;
    if (state == START) begin
      eng_start = N_ENG'(1) << idx;
    end
  end

  // engine index and frame busy flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx  <= '0;
      busy <= 1'b0;
    end else begin
      case (state)
        SNAP: begin
          idx  <= IDX_W'(ENG_CLEAR);
          busy <= 1'b1;
        end
        NEXT: if (!last_eng) idx <= idx + IDX_W'(1);
        DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end

  // one-deep request queue; a request in DONE is folded into the restart
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
    end else if (state == IDLE) begin
      pending <= 1'b0;
    end else if (state == DONE) begin
      pending <= pending & req;
    end else if (req) begin
      pending <= 1'b1;
    end
  end

  // sticky error flags; a set in the clearing cycle takes priority
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      overrun     <= overrun_set | (overrun & ~clr_status);
      timeout_err <= timeout_set | (timeout_err & ~clr_status);
    end
  end

  // registered pixel mux from the engine that owns the framebuffer port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fb_x     <= '0;
      fb_y     <= '0;
      fb_color <= 1'b0;
      fb_write <= 1'b0;
    end else if (state == RUN) begin
      fb_x     <= eng_x[idx*COORD_W +: COORD_W];
      fb_y     <= eng_y[idx*COORD_W +: COORD_W];
      fb_color <= eng_color[idx];
      fb_write <= eng_wr[idx];
    end else begin
      fb_write <= 1'b0;
    end
  end

  assign active_eng = idx;

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// tb/tb_frame_draw_scheduler.sv - self-checking bench for frame_draw_scheduler
module tb_frame_draw_scheduler;
  import draw_pkg::*;

  localparam int NE = 4;
  localparam int CW = 11;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             frame_tick;
  logic             enable;
  logic             clr_status;
  logic [NE-1:0]    eng_start;
  logic [NE-1:0]    eng_done;
  logic [NE*CW-1:0] eng_x;
  logic [NE*CW-1:0] eng_y;
  logic [NE-1:0]    eng_color;
  logic [NE-1:0]    eng_wr;
  logic [CW-1:0]    fb_x;
  logic [CW-1:0]    fb_y;
  logic             fb_color;
  logic             fb_write;
  logic             latch_coords;
  logic             busy;
  logic             frame_done;
  logic [1:0]       active_eng;
  logic             overrun;
  logic             timeout_err;

  int tests_run    = 0;
  int tests_failed = 0;

  int cyc        = 0;
  int latch_cnt  = 0;
  int latch_cyc  = -1;
  int done_cnt   = 0;
  int done_cyc   = -1;
  int start2_cyc = -1;
  int bird_cyc   = -1;
  int pix_seen   = 0;

  logic [NE-1:0] exp_start[$];
  logic [22:0]   exp_pix[$];
  logic [NE-1:0] exp_s;
  logic [22:0]   exp_p;

  int cnt[NE];
  bit act[NE];
  bit hang[NE];
  bit pix2_en   = 1'b0;
  bit noise1_en = 1'b0;

  frame_draw_scheduler #(
    .N_ENG(NE),
    .COORD_W(CW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_tick(frame_tick),
    .enable(enable),
    .clr_status(clr_status),
    .eng_start(eng_start),
    .eng_done(eng_done),
    .eng_x(eng_x),
    .eng_y(eng_y),
    .eng_color(eng_color),
    .eng_wr(eng_wr),
    .fb_x(fb_x),
    .fb_y(fb_y),
    .fb_color(fb_color),
    .fb_write(fb_write),
    .latch_coords(latch_coords),
    .busy(busy),
    .frame_done(frame_done),
    .active_eng(active_eng),
    .overrun(overrun),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  // monitor/scoreboard first, then engine models drive the next half cycle
  initial begin
    eng_done  = '0;
    eng_wr    = '0;
    eng_color = '0;
    eng_x     = '0;
    eng_y     = '0;
    for (int i = 0; i < NE; i++) begin
      cnt[i] = 0;
      act[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      if (eng_start != '0) begin
        if (eng_start == NE'(1 << ENG_PIPE2)) start2_cyc = cyc;
        if (eng_start == NE'(1 << ENG_BIRD)) bird_cyc = cyc;
        tests_run++;
        if (exp_start.size() == 0) begin
          tests_failed++;
          $display("FAIL start_unexpected: eng_start=%b, required none at cycle %0d", eng_start, cyc);
        end else begin
          exp_s = exp_start.pop_front();
          if (eng_start !== exp_s) begin
            tests_failed++;
            $display("FAIL start_order: eng_start=%b, required %b", eng_start, exp_s);
          end
        end
      end
      if (latch_coords === 1'b1) begin
        latch_cnt++;
        latch_cyc = cyc;
      end
      if (frame_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (fb_write === 1'b1) begin
        pix_seen++;
        tests_run++;
        if (exp_pix.size() == 0) begin
          tests_failed++;
          $display("FAIL pix_unexpected: fb x=%0d y=%0d c=%0d, required no write", fb_x, fb_y, fb_color);
        end else begin
          exp_p = exp_pix.pop_front();
          if ({fb_x, fb_y, fb_color} !== exp_p) begin
            tests_failed++;
            $display("FAIL pix_data: fb x=%0d y=%0d c=%0d, required x=%0d y=%0d c=%0d",
                     fb_x, fb_y, fb_color, exp_p[22:12], exp_p[11:1], exp_p[0]);
          end
        end
      end

      for (int i = 0; i < NE; i++) begin
        eng_done[i] = 1'b0;
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            act[i] = 1'b0;
            if (!hang[i]) eng_done[i] = 1'b1;
          end
        end
        if (eng_start[i] === 1'b1) begin
          cnt[i] = 5;
          act[i] = 1'b1;
        end
        eng_x[i*CW +: CW] = CW'(i + 1);
        eng_y[i*CW +: CW] = CW'(i + 2);
        eng_color[i]      = 1'b0;
      end
      eng_wr = '0;
      if (pix2_en && act[ENG_PIPE2]) begin
        eng_x[ENG_PIPE2*CW +: CW] = CW'(100);
        eng_y[ENG_PIPE2*CW +: CW] = CW'(250);
        eng_color[ENG_PIPE2]      = 1'b1;
        eng_wr[ENG_PIPE2]         = 1'b1;
        if (cnt[ENG_PIPE2] < 5) exp_pix.push_back({11'd100, 11'd250, 1'b1});
      end
      if (noise1_en && act[ENG_PIPE2]) begin
        eng_x[ENG_PIPE1*CW +: CW] = CW'(7);
        eng_y[ENG_PIPE1*CW +: CW] = CW'(9);
        eng_color[ENG_PIPE1]      = 1'b0;
        eng_wr[ENG_PIPE1]         = 1'b1;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic push_frame_starts();
    for (int i = 0; i < NE; i++) exp_start.push_back(NE'(1 << i));
  endtask

  task automatic fire_and_wait(output int edge_c, output bit ok, output int busy_gap);
    int base_d;
    base_d   = done_cnt;
    busy_gap = 0;
    ok       = 1'b0;
    step();
    frame_tick = 1'b1;
    edge_c     = cyc;
    for (int k = 0; k < 80; k++) begin
      step();
      if (k == 2) frame_tick = 1'b0;
      if ((cyc > edge_c + 1) && (busy !== 1'b1)) busy_gap++;
      if (done_cnt != base_d) begin
        ok = 1'b1;
        break;
      end
    end
    frame_tick = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    frame_tick = 1'b0;
    enable     = 1'b1;
    clr_status = 1'b0;
    steps(3);
    tests_run++;
    if ({eng_start, latch_coords, busy, frame_done, fb_write, fb_color} !== 9'd0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: start=%b latch=%b busy=%b done=%b wr=%b c=%b, required all 0",
               eng_start, latch_coords, busy, frame_done, fb_write, fb_color);
    end
    tests_run++;
    if ({fb_x, fb_y, active_eng} !== 24'd0) begin
      tests_failed++;
      $display("FAIL reset_data: fb_x=%0d fb_y=%0d active=%0d, required 0", fb_x, fb_y, active_eng);
    end
    tests_run++;
    if ({overrun, timeout_err} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_status: overrun=%b timeout_err=%b, required 0", overrun, timeout_err);
    end
    reset = 1'b1;
    steps(2);
  endtask

  task automatic test_single_frame();
    int edge_c, gap, base_l, base_d;
    bit ok;
    base_l = latch_cnt;
    base_d = done_cnt;
    push_frame_starts();
    fire_and_wait(edge_c, ok, gap);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL single_done_wait: frame_done not seen, required within 80 cycles");
    end
    tests_run++;
    if (latch_cyc !== edge_c + 1 || latch_cnt - base_l !== 1) begin
      tests_failed++;
      $display("FAIL single_latch: at %0d count %0d, required at %0d count 1", latch_cyc, latch_cnt - base_l, edge_c + 1);
    end
    tests_run++;
    if (bird_cyc !== edge_c + 23) begin
      tests_failed++;
      $display("FAIL single_bird_start: at %0d, required %0d", bird_cyc, edge_c + 23);
    end
    tests_run++;
    if (done_cyc !== edge_c + 30 || done_cnt - base_d !== 1) begin
      tests_failed++;
      $display("FAIL single_done: at %0d count %0d, required at %0d count 1", done_cyc, done_cnt - base_d, edge_c + 30);
    end
    tests_run++;
    if (gap !== 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_busy: gaps=%0d after=%b, required 0 and 0", gap, busy);
    end
    tests_run++;
    if (exp_start.size() !== 0 || overrun !== 1'b0 || timeout_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_status: starts_left=%0d overrun=%b timeout=%b, required 0 0 0",
               exp_start.size(), overrun, timeout_err);
    end
  endtask

  task automatic test_pixel_mux();
    int edge_c, gap, base_p;
    bit ok;
    base_p    = pix_seen;
    pix2_en   = 1'b1;
    noise1_en = 1'b1;
    push_frame_starts();
    fire_and_wait(edge_c, ok, gap);
    pix2_en   = 1'b0;
    noise1_en = 1'b0;
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL pix_done_wait: frame_done not seen, required within 80 cycles");
    end
    tests_run++;
    if (pix_seen - base_p !== 4 || exp_pix.size() !== 0) begin
      tests_failed++;
      $display("FAIL pix_count: writes=%0d left=%0d, required 4 and 0", pix_seen - base_p, exp_pix.size());
    end
    tests_run++;
    if (fb_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL pix_idle_write: fb_write=%b, required 0", fb_write);
    end
  endtask

  task automatic test_timeout();
    int edge_c, gap;
    bit ok;
    hang[ENG_PIPE1] = 1'b1;
    push_frame_starts();
    fire_and_wait(edge_c, ok, gap);
    hang[ENG_PIPE1] = 1'b0;
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL to_done_wait: frame_done not seen, required within 80 cycles");
    end
    tests_run++;
    if (start2_cyc !== edge_c + 27) begin
      tests_failed++;
      $display("FAIL to_next_start: engine 2 started at %0d, required %0d", start2_cyc, edge_c + 27);
    end
    tests_run++;
    if (done_cyc !== edge_c + 41) begin
      tests_failed++;
      $display("FAIL to_done_cycle: at %0d, required %0d", done_cyc, edge_c + 41);
    end
    tests_run++;
    if (timeout_err !== 1'b1 || overrun !== 1'b0 || exp_start.size() !== 0) begin
      tests_failed++;
      $display("FAIL to_status: timeout=%b overrun=%b starts_left=%0d, required 1 0 0",
               timeout_err, overrun, exp_start.size());
    end
  endtask

  task automatic test_back_to_back();
    int edge_c, base_d, base_l;
    bit ok;
    base_d = done_cnt;
    base_l = latch_cnt;
    ok     = 1'b0;
    push_frame_starts();
    push_frame_starts();
    step();
    frame_tick = 1'b1;
    edge_c     = cyc;
    steps(3);
    frame_tick = 1'b0;
    steps(2);
    frame_tick = 1'b1;
    steps(2);
    frame_tick = 1'b0;
    steps(2);
    frame_tick = 1'b1;
    steps(2);
    frame_tick = 1'b0;
    for (int k = 0; k < 120; k++) begin
      step();
      if (done_cnt - base_d >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    steps(40);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL b2b_done_wait: 2 frame_done pulses not seen, required within 120 cycles");
    end
    tests_run++;
    if (done_cnt - base_d !== 2 || latch_cnt - base_l !== 2) begin
      tests_failed++;
      $display("FAIL b2b_count: done=%0d latch=%0d, required 2 and 2", done_cnt - base_d, latch_cnt - base_l);
    end
    tests_run++;
    if (latch_cyc !== edge_c + 31 || done_cyc !== edge_c + 60) begin
      tests_failed++;
      $display("FAIL b2b_timing: latch at %0d done at %0d, required %0d and %0d",
               latch_cyc, done_cyc, edge_c + 31, edge_c + 60);
    end
    tests_run++;
    if (overrun !== 1'b1 || timeout_err !== 1'b1 || exp_start.size() !== 0) begin
      tests_failed++;
      $display("FAIL b2b_status: overrun=%b timeout=%b starts_left=%0d, required 1 1 0",
               overrun, timeout_err, exp_start.size());
    end
  endtask

  task automatic test_clr_status();
    step();
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    step();
    tests_run++;
    if (overrun !== 1'b0 || timeout_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL clr_status: overrun=%b timeout=%b, required 0 0", overrun, timeout_err);
    end
  endtask

  task automatic test_enable_low();
    int base_l, busy_hi;
    base_l  = latch_cnt;
    busy_hi = 0;
    enable  = 1'b0;
    step();
    frame_tick = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (busy !== 1'b0) busy_hi++;
    end
    frame_tick = 1'b0;
    step();
    enable = 1'b1;
    step();
    tests_run++;
    if (latch_cnt !== base_l || busy_hi !== 0) begin
      tests_failed++;
      $display("FAIL enable_low: latches=%0d busy_cycles=%0d, required 0 and 0", latch_cnt - base_l, busy_hi);
    end
  endtask

  task automatic test_reset_mid_run();
    int edge_c, gap;
    bit ok;
    exp_start.push_back(NE'(1 << ENG_CLEAR));
    exp_start.push_back(NE'(1 << ENG_PIPE1));
    step();
    frame_tick = 1'b1;
    edge_c     = cyc;
    steps(3);
    frame_tick = 1'b0;
    steps(9);
    tests_run++;
    if (busy !== 1'b1 || active_eng !== 2'(ENG_PIPE1) || fb_x !== 11'd2) begin
      tests_failed++;
      $display("FAIL mid_run_state: busy=%b active=%0d fb_x=%0d, required 1 1 2", busy, active_eng, fb_x);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if ({eng_start, latch_coords, busy, frame_done, fb_write, fb_color, overrun, timeout_err} !== 11'd0) begin
      tests_failed++;
      $display("FAIL mid_reset_ctrl: start=%b busy=%b wr=%b ovr=%b to=%b, required all 0",
               eng_start, busy, fb_write, overrun, timeout_err);
    end
    tests_run++;
    if ({fb_x, fb_y, active_eng} !== 24'd0) begin
      tests_failed++;
      $display("FAIL mid_reset_data: fb_x=%0d fb_y=%0d active=%0d, required 0", fb_x, fb_y, active_eng);
    end
    steps(2);
    reset = 1'b1;
    steps(10);
    tests_run++;
    if (exp_start.size() !== 0) begin
      tests_failed++;
      $display("FAIL mid_reset_starts: %0d starts missing, required 0", exp_start.size());
    end
    push_frame_starts();
    fire_and_wait(edge_c, ok, gap);
    tests_run++;
    if (!ok || latch_cyc !== edge_c + 1 || done_cyc !== edge_c + 30 || gap !== 0) begin
      tests_failed++;
      $display("FAIL post_reset_frame: ok=%b latch=%0d done=%0d gaps=%0d, required 1 %0d %0d 0",
               ok, latch_cyc, done_cyc, gap, edge_c + 1, edge_c + 30);
    end
    tests_run++;
    if (timeout_err !== 1'b0 || overrun !== 1'b0 || exp_start.size() !== 0) begin
      tests_failed++;
      $display("FAIL post_reset_status: timeout=%b overrun=%b starts_left=%0d, required 0 0 0",
               timeout_err, overrun, exp_start.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_pixel_mux();
    test_timeout();
    test_back_to_back();
    test_clr_status();
    test_enable_low();
    test_reset_mid_run();
    tests_run++;
    if (exp_pix.size() !== 0) begin
      tests_failed++;
      $display("FAIL pix_leftover: %0d expected writes never seen, required 0", exp_pix.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
